// File: rtl/pen_capture.sv
// Light-pen conditioning: synchronise pen/key pins, filter glitches, emit one
// fixed-width we burst per touch followed by a refractory lockout.
module pen_capture #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 4,
  parameter int HOLD_CYCLES    = 16,
  parameter int LOCKOUT_CYCLES = 64,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             pen_in,
  input  logic             key_in,
  input  logic             clr_cnt,
  output logic             we,
  output logic             busy,
  output logic             pen_level,
  output logic [CNT_W-1:0] hit_count
);

  typedef enum logic [2:0] {IDLE, FILTER, HOLD, LOCKOUT, WAIT_LOW} state_t;

  localparam logic [15:0] FILT_C = 16'(FILTER_LEN);
  localparam logic [15:0] HOLD_C = 16'(HOLD_CYCLES);
  localparam logic [15:0] LOCK_C = 16'(LOCKOUT_CYCLES);

  state_t                 state, state_nx;
  logic [SYNC_STAGES-1:0] pen_sync, key_sync;
  logic [15:0]            cnt, cnt_nx;
  logic                   pen_s, key_s, go, hold_entry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pen_sync <= '0;
      key_sync <= '0;
    end else begin
      pen_sync <= {pen_sync[SYNC_STAGES-2:0], pen_in};
      key_sync <= {key_sync[SYNC_STAGES-2:0], key_in};
    end
  end

  assign pen_s     = pen_sync[SYNC_STAGES-1];
  assign key_s     = key_sync[SYNC_STAGES-1];
  assign pen_level = pen_s;
  assign go        = enable & key_s & pen_s;

  // One shared counter: filter run length, then HOLD and LOCKOUT clock counts.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    if (!enable) begin
      state_nx = IDLE;
      cnt_nx   = '0;
    end else begin
      unique case (state)
        IDLE: if (go) begin
          cnt_nx   = 16'd1;
          state_nx = (FILTER_LEN == 1) ? HOLD : FILTER;
        end
        FILTER: begin
          if (!go) begin
            state_nx = IDLE;
            cnt_nx   = '0;
          end else if (cnt + 16'd1 == FILT_C) begin
            state_nx = HOLD;
            cnt_nx   = 16'd1;
          end else begin
            cnt_nx = cnt + 16'd1;
          end
        end
        HOLD: begin
          if (cnt == HOLD_C) begin
            state_nx = LOCKOUT;
            cnt_nx   = 16'd1;
          end else begin
            cnt_nx = cnt + 16'd1;
          end
        end
        LOCKOUT: begin
          if (cnt == LOCK_C) begin
            state_nx = WAIT_LOW;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + 16'd1;
          end
        end
        WAIT_LOW: if (!pen_s) state_nx = IDLE;
        default: begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  assign hold_entry = (state_nx == HOLD) && (state != HOLD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      we        <= 1'b0;
      busy      <= 1'b0;
      hit_count <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      we    <= (state_nx == HOLD);
      busy  <= (state_nx != IDLE);
      // Clear beats a coincident touch; count saturates rather than wraps.
      if (clr_cnt)
        hit_count <= '0;
      else if (hold_entry && (hit_count != '1))
        hit_count <= hit_count + 1'b1;
    end
  end

endmodule
